// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared ALU, memory port and
// register file, driving datapath write enables and mux selects, and counts
// retired instructions.
// Optional build macro: MC_CTRL_ILLEGAL_TRAP_EN -- when defined, an unsupported
// opcode/funct parks the FSM in TRAP with a sticky illegal flag; when undefined,
// unsupported encodings retire as nop and illegal is tied low.
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             mem_we,
    output logic [1:0]       npc_sel,
    output logic [1:0]       a3_sel,
    output logic [1:0]       wd_sel,
    output logic             alub_sel,
    output logic             ext_op,
    output logic [2:0]       alu_op,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             illegal
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_retire;

    logic w_ir_we, w_pc_we, w_reg_we, w_mem_we;
    logic [1:0] w_npc_sel, w_a3_sel, w_wd_sel;
    logic w_alub_sel, w_ext_op;
    logic [2:0] w_alu_op;

    // ALU control for the current instruction, held across EXEC/MEM/WB
    logic [2:0] w_ex_alu_op;
    logic       w_ex_alub_sel;
    logic       w_ex_ext_op;

    // Instruction decode
    logic w_rtype, w_op_addu, w_op_subu, w_op_jr, w_op_nop;
    logic w_op_ori, w_op_lui, w_op_lw, w_op_sw, w_op_beq, w_op_j, w_op_jal;
    logic w_exec_class;

    assign w_rtype   = (opcode == 6'b000000);
    assign w_op_addu = w_rtype && (funct == 6'b100001);
    assign w_op_subu = w_rtype && (funct == 6'b100011);
    assign w_op_jr   = w_rtype && (funct == 6'b001000);
    assign w_op_nop  = w_rtype && (funct == 6'b000000);
    assign w_op_ori  = (opcode == 6'b001101);
    assign w_op_lui  = (opcode == 6'b001111);
    assign w_op_lw   = (opcode == 6'b100011);
    assign w_op_sw   = (opcode == 6'b101011);
    assign w_op_beq  = (opcode == 6'b000100);
    assign w_op_j    = (opcode == 6'b000010);
    assign w_op_jal  = (opcode == 6'b000011);

    // Instructions that need the ALU go on to EXEC; jumps and nop finish in DECODE
    assign w_exec_class = w_op_addu | w_op_subu | w_op_ori | w_op_lui |
                          w_op_lw | w_op_sw | w_op_beq;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic w_legal;
    assign w_legal = w_exec_class | w_op_j | w_op_jal | w_op_jr | w_op_nop;
`endif

    // Per-instruction ALU operation, operand-B source and immediate extension
    always_comb begin
        w_ex_alu_op   = 3'b000;
        w_ex_alub_sel = 1'b0;
        w_ex_ext_op   = 1'b0;
        if (w_op_subu) begin
            w_ex_alu_op = 3'b001;
        end else if (w_op_ori) begin
            w_ex_alu_op   = 3'b010;
            w_ex_alub_sel = 1'b1;
        end else if (w_op_lui) begin
            w_ex_alu_op   = 3'b011;
            w_ex_alub_sel = 1'b1;
        end else if (w_op_lw || w_op_sw) begin
            w_ex_alub_sel = 1'b1;
            w_ex_ext_op   = 1'b1;
        end else if (w_op_beq) begin
            w_ex_alu_op = 3'b001;
            w_ex_ext_op = 1'b1;
        end
    end

    // Next-state and datapath control per state
    always_comb begin
        w_next     = S_FETCH;
        w_ir_we    = 1'b0;
        w_pc_we    = 1'b0;
        w_reg_we   = 1'b0;
        w_mem_we   = 1'b0;
        w_npc_sel  = 2'b00;
        w_a3_sel   = 2'b00;
        w_wd_sel   = 2'b00;
        w_alub_sel = 1'b0;
        w_ext_op   = 1'b0;
        w_alu_op   = 3'b000;
        case (r_state)
            S_FETCH: begin
                w_ir_we = 1'b1;
                w_pc_we = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                if (w_op_j) begin
                    w_pc_we   = 1'b1;
                    w_npc_sel = 2'b10;
                end else if (w_op_jal) begin
                    w_pc_we   = 1'b1;
                    w_npc_sel = 2'b10;
                    w_reg_we  = 1'b1;
                    w_a3_sel  = 2'b10;
                    w_wd_sel  = 2'b10;
                end else if (w_op_jr) begin
                    w_pc_we   = 1'b1;
                    w_npc_sel = 2'b11;
                end else if (w_exec_class) begin
                    w_next = S_EXEC;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                end else if (!w_legal) begin
                    w_next = S_TRAP;
`endif
                end
            end
            S_EXEC: begin
                w_alu_op   = w_ex_alu_op;
                w_alub_sel = w_ex_alub_sel;
                w_ext_op   = w_ex_ext_op;
                if (w_op_lw || w_op_sw) begin
                    w_next = S_MEM;
                end else if (w_op_beq) begin
                    w_npc_sel = 2'b01;
                    w_pc_we   = zero;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_alu_op   = w_ex_alu_op;
                w_alub_sel = w_ex_alub_sel;
                w_ext_op   = w_ex_ext_op;
                if (w_op_sw) begin
                    w_mem_we = 1'b1;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                w_alu_op   = w_ex_alu_op;
                w_alub_sel = w_ex_alub_sel;
                w_ext_op   = w_ex_ext_op;
                w_reg_we   = 1'b1;
                w_a3_sel   = (w_op_addu || w_op_subu) ? 2'b01 : 2'b00;
                w_wd_sel   = w_op_lw ? 2'b01 : 2'b00;
            end
            S_TRAP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                w_next = S_TRAP;
`else
                w_next = S_FETCH;
`endif
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_TRAP);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_cnt <= '0;
        else if (w_retire) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;

    // Sticky trap flag, set on the edge that enters TRAP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_illegal <= 1'b0;
        else       r_illegal <= r_illegal | (w_next == S_TRAP);
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    // Writes are suppressed for as long as reset is held, so an aborted
    // instruction never commits anything
    assign ir_we     = w_ir_we  & ~reset;
    assign pc_we     = w_pc_we  & ~reset;
    assign reg_we    = w_reg_we & ~reset;
    assign mem_we    = w_mem_we & ~reset;
    assign npc_sel   = w_npc_sel;
    assign a3_sel    = w_a3_sel;
    assign wd_sel    = w_wd_sel;
    assign alub_sel  = w_alub_sel;
    assign ext_op    = w_ext_op;
    assign alu_op    = w_alu_op;
    assign state     = r_state;
    assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: a 32-bit-counter instance and a 4-bit-counter
// instance share stimulus; a per-instruction cycle-table model supplies the
// expected outputs for every cycle, plus literal checks on key scenarios.
module tb_mc_ctrl_fsm;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic zero;

  always #5 clk = ~clk;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic a_ir_we, a_pc_we, a_reg_we, a_mem_we, a_alub, a_ext, a_ill;
  logic [1:0] a_npc, a_a3, a_wd;
  logic [2:0] a_aluop, a_state;
  logic [31:0] a_cnt;

  logic b_ir_we, b_pc_we, b_reg_we, b_mem_we, b_alub, b_ext, b_ill;
  logic [1:0] b_npc, b_a3, b_wd;
  logic [2:0] b_aluop, b_state;
  logic [3:0] b_cnt;

  mc_ctrl_fsm u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .ir_we(a_ir_we), .pc_we(a_pc_we), .reg_we(a_reg_we), .mem_we(a_mem_we),
    .npc_sel(a_npc), .a3_sel(a_a3), .wd_sel(a_wd), .alub_sel(a_alub),
    .ext_op(a_ext), .alu_op(a_aluop), .state(a_state), .instr_cnt(a_cnt),
    .illegal(a_ill)
  );

  mc_ctrl_fsm #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .ir_we(b_ir_we), .pc_we(b_pc_we), .reg_we(b_reg_we), .mem_we(b_mem_we),
    .npc_sel(b_npc), .a3_sel(b_a3), .wd_sel(b_wd), .alub_sel(b_alub),
    .ext_op(b_ext), .alu_op(b_aluop), .state(b_state), .instr_cnt(b_cnt),
    .illegal(b_ill)
  );

  // ---------------- model ----------------
  typedef struct packed {
    logic [2:0] st;
    logic ir_we, pc_we, reg_we, mem_we;
    logic [1:0] npc, a3, wd;
    logic alub, ext;
    logic [2:0] aluop;
    logic ill;
    logic zdep;   // pc_we follows the zero flag in this cycle
  } vec_t;

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_NOP = 3, K_ORI = 4, K_LUI = 5;
  localparam int K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JAL = 10, K_ILL = 11;

  vec_t exp_q[$];
  logic [31:0] m_cnt;
  int checks = 0;
  int errors = 0;
  int zero_mode = -1;   // -1 random, else forced value

  function automatic int classify(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b000000: begin
        case (fn)
          6'b100001: return K_ADDU;
          6'b100011: return K_SUBU;
          6'b001000: return K_JR;
          6'b000000: return K_NOP;
          default:   return K_ILL;
        endcase
      end
      6'b001101: return K_ORI;
      6'b001111: return K_LUI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  // Expected cycle-by-cycle outputs of one instruction
  task automatic build(input int k);
    vec_t e;
    vec_t ac;
    e = '0; e.st = 3'd0; e.ir_we = 1'b1; e.pc_we = 1'b1;
    exp_q.push_back(e);
    e = '0; e.st = 3'd1;
    if (k == K_J)   begin e.pc_we = 1'b1; e.npc = 2'b10; end
    if (k == K_JAL) begin e.pc_we = 1'b1; e.npc = 2'b10; e.reg_we = 1'b1; e.a3 = 2'b10; e.wd = 2'b10; end
    if (k == K_JR)  begin e.pc_we = 1'b1; e.npc = 2'b11; end
    exp_q.push_back(e);
    if (k == K_ILL && TRAP_EN) begin
      for (int i = 0; i < 12; i++) begin
        e = '0; e.st = 3'd7; e.ill = 1'b1;
        exp_q.push_back(e);
      end
    end
    if (k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LUI ||
        k == K_LW || k == K_SW || k == K_BEQ) begin
      ac = '0;
      case (k)
        K_SUBU: ac.aluop = 3'b001;
        K_ORI:  begin ac.aluop = 3'b010; ac.alub = 1'b1; end
        K_LUI:  begin ac.aluop = 3'b011; ac.alub = 1'b1; end
        K_LW, K_SW: begin ac.alub = 1'b1; ac.ext = 1'b1; end
        K_BEQ:  begin ac.aluop = 3'b001; ac.ext = 1'b1; end
        default: ;
      endcase
      e = ac; e.st = 3'd2;
      if (k == K_BEQ) begin e.npc = 2'b01; e.zdep = 1'b1; end
      exp_q.push_back(e);
      if (k == K_LW || k == K_SW) begin
        e = ac; e.st = 3'd3; e.mem_we = (k == K_SW);
        exp_q.push_back(e);
      end
      if (k != K_BEQ && k != K_SW) begin
        e = ac; e.st = 3'd4; e.reg_we = 1'b1;
        e.a3 = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
        e.wd = (k == K_LW) ? 2'b01 : 2'b00;
        exp_q.push_back(e);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  function automatic logic [31:0] pack_a();
    vec_t v;
    v = {a_state, a_ir_we, a_pc_we, a_reg_we, a_mem_we, a_npc, a_a3, a_wd,
         a_alub, a_ext, a_aluop, a_ill, 1'b0};
    return 32'(v);
  endfunction

  function automatic logic [31:0] pack_b();
    vec_t v;
    v = {b_state, b_ir_we, b_pc_we, b_reg_we, b_mem_we, b_npc, b_a3, b_wd,
         b_alub, b_ext, b_aluop, b_ill, 1'b0};
    return 32'(v);
  endfunction

  function automatic logic pick_zero();
    if (zero_mode < 0) return 1'($urandom_range(0, 1));
    return 1'(zero_mode);
  endfunction

  // One clock cycle: compare at the falling edge, advance, re-drive zero
  task automatic do_cycle();
    vec_t e;
    e = exp_q.pop_front();
    if (e.zdep) e.pc_we = zero;
    e.zdep = 1'b0;
    @(negedge clk);
    chk("outputs", pack_a(), 32'(e));
    chk("outputs_cnt4", pack_b(), 32'(e));
    chk("instr_cnt", a_cnt, m_cnt);
    chk("instr_cnt4", {28'd0, b_cnt}, {28'd0, m_cnt[3:0]});
    @(posedge clk);
    #1;
    zero = pick_zero();
  endtask

  // Called at posedge+1; leaves reset released at posedge+1
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_enables", {28'd0, a_ir_we, a_pc_we, a_reg_we, a_mem_we}, 32'd0);
    chk("rst_state", {29'd0, a_state}, 32'd0);
    chk("rst_cnt", a_cnt, 32'd0);
    chk("rst_illegal", {31'd0, a_ill}, 32'd0);
    m_cnt = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- driver ----------------
  // stop_after < 0 runs the whole instruction; otherwise stops after that many cycles
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int stop_after, output int ncyc);
    int k;
    k = classify(op, fn);
    opcode = op;
    funct  = fn;
    build(k);
    ncyc = 0;
    while (exp_q.size() > 0 && (stop_after < 0 || ncyc < stop_after)) begin
      do_cycle();
      ncyc++;
    end
    if (stop_after >= 0) begin
      exp_q.delete();
    end else if (k == K_ILL && TRAP_EN) begin
      do_reset();
    end else begin
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  logic [5:0] op_tab [12] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001111,
                              6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011, 6'b111111};
  logic [5:0] fn_tab [12] = '{6'b100001, 6'b100011, 6'b001000, 6'b000000, 6'b000000, 6'b000000,
                              6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};

  initial begin
    int n;
    int tot;
    int idx;
    reset  = 1'b1;
    opcode = 6'd0;
    funct  = 6'd0;
    zero   = 1'b0;
    m_cnt  = '0;
    @(posedge clk);
    #1;
    do_reset();

    // ori, addu, lw, sw from reset: 17 cycles, four retired
    tot = 0;
    run_instr(6'b001101, 6'b000000, -1, n); tot += n;
    run_instr(6'b000000, 6'b100001, -1, n); tot += n;
    run_instr(6'b100011, 6'b000000, -1, n); tot += n;
    run_instr(6'b101011, 6'b000000, -1, n); tot += n;
    chk("seq_cycles", 32'(tot), 32'd17);
    chk("seq_cnt", a_cnt, 32'd4);

    // beq taken then not taken
    zero_mode = 1; zero = 1'b1;
    run_instr(6'b000100, 6'b000000, -1, n);
    chk("beq_taken_cycles", 32'(n), 32'd3);
    zero_mode = 0; zero = 1'b0;
    run_instr(6'b000100, 6'b000000, -1, n);
    chk("beq_not_taken_cycles", 32'(n), 32'd3);
    zero_mode = -1;

    // jal then jr
    run_instr(6'b000011, 6'b000000, -1, n);
    chk("jal_cycles", 32'(n), 32'd2);
    run_instr(6'b000000, 6'b001000, -1, n);
    chk("jr_cycles", 32'(n), 32'd2);

    // Reset during addu write-back
    run_instr(6'b000000, 6'b100001, 3, n);
    chk("wb_reg_we", {31'd0, a_reg_we}, 32'd1);
    chk("wb_state", {29'd0, a_state}, 32'd4);
    do_reset();
    run_instr(6'b000000, 6'b000000, -1, n);

    // 17 nops from reset: 4-bit counter wraps to 1
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(6'b000000, 6'b000000, -1, n);
    chk("wrap_cnt4", {28'd0, b_cnt}, 32'd1);
    chk("wrap_cnt32", a_cnt, 32'd17);

    // Unsupported opcode
    tot = int'(m_cnt);
    run_instr(6'b111111, 6'b000000, -1, n);
    if (TRAP_EN) begin
      chk("trap_cycles", 32'(n), 32'd14);
    end else begin
      chk("illegal_nop_cycles", 32'(n), 32'd2);
      chk("illegal_nop_cnt", a_cnt, 32'(tot + 1));
    end

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      idx = $urandom_range(0, 11);
      if (idx == 11 && $urandom_range(0, 3) != 0) idx = 3;
      if (idx == 3 && $urandom_range(0, 1) == 1) begin
        run_instr(6'b000000, 6'($urandom_range(0, 63)), -1, n);
      end else begin
        run_instr(op_tab[idx], fn_tab[idx], -1, n);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
